vx_ahb_burst_adapter: RTL and testbench

Bridges one Vortex memory request/response port to an AHB5 manager interface. Each cache-line request is split into BEATS = VX_DATA_WIDTH/AHB_DATA_WIDTH beats and issued as a pipelined INCR burst, with address phase k+1 overlapping data phase k. Read beats are reassembled into a line, returned with the captured tag, and flagged on error. Sits between the Vortex memory arbiter output and the SoC AHB fabric.

---
 rtl/vx_ahb_burst_adapter.sv | 174 +++++++++++++++++
 tb/tb_vx_ahb_burst_adapter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ahb_burst_adapter.sv
// Vortex line request/response port to AHB5 manager: splits each line into a pipelined INCR burst.
// Optional HWSTRB port and byte-enable forwarding under `define VX_AHB_WSTRB_EN.
module vx_ahb_burst_adapter #(
   parameter int unsigned VX_DATA_WIDTH  = 512,
   parameter int unsigned VX_ADDR_WIDTH  = 32 - $clog2(VX_DATA_WIDTH/8),
   parameter int unsigned VX_TAG_WIDTH   = 8,
   parameter int unsigned AHB_DATA_WIDTH = 32,
   parameter int unsigned AHB_ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mem_req_valid,
   output logic                         mem_req_ready,
   input  logic                         mem_req_rw,
   input  logic [VX_DATA_WIDTH/8-1:0]   mem_req_byteen,
   input  logic [VX_ADDR_WIDTH-1:0]     mem_req_addr,
   input  logic [VX_DATA_WIDTH-1:0]     mem_req_data,
   input  logic [VX_TAG_WIDTH-1:0]      mem_req_tag,
   output logic                         mem_rsp_valid,
   input  logic                         mem_rsp_ready,
   output logic [VX_DATA_WIDTH-1:0]     mem_rsp_data,
   output logic [VX_TAG_WIDTH-1:0]      mem_rsp_tag,
   output logic                         mem_rsp_err,
   output logic                         HSEL,
   output logic [AHB_ADDR_WIDTH-1:0]    HADDR,
   output logic [1:0]                   HTRANS,
   output logic [2:0]                   HBURST,
   output logic [2:0]                   HSIZE,
   output logic                         HWRITE,
   output logic [AHB_DATA_WIDTH-1:0]    HWDATA,
`ifdef VX_AHB_WSTRB_EN
   output logic [AHB_DATA_WIDTH/8-1:0]  HWSTRB,
`endif
   input  logic [AHB_DATA_WIDTH-1:0]    HRDATA,
   input  logic                         HREADY,
   input  logic                         HRESP
);

   localparam int unsigned BEATS      = VX_DATA_WIDTH / AHB_DATA_WIDTH;
   localparam int unsigned LINE_OFS   = $clog2(VX_DATA_WIDTH / 8);
   localparam int unsigned BEAT_BYTES = AHB_DATA_WIDTH / 8;
   localparam int unsigned BEAT_OFS   = $clog2(BEAT_BYTES);
   localparam int unsigned CW         = $clog2(BEATS + 1);
   localparam int unsigned IW         = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR, S_RESP} state_t;

   state_t                                  state_q, state_d;
   logic [CW-1:0]                           acnt_q, acnt_d, dcnt_q, dcnt_d;
   logic                                    rw_q, rw_d, err_q, err_d, ready_q;
   logic [AHB_ADDR_WIDTH-1:0]               base_q, base_d;
   logic [BEATS-1:0][AHB_DATA_WIDTH-1:0]    line_q, line_d;
   logic [VX_TAG_WIDTH-1:0]                 tag_q, tag_d;
`ifdef VX_AHB_WSTRB_EN
   logic [BEATS-1:0][BEAT_BYTES-1:0]        be_q, be_d;
`else
   logic                                    unused_byteen;
   assign unused_byteen = ^mem_req_byteen;
`endif

   logic          aphase, dphase;
   logic [IW-1:0] didx;

   assign aphase = (state_q == S_BURST) && (acnt_q < CW'(BEATS));
   assign dphase = (state_q == S_BURST) && (dcnt_q < acnt_q);
   assign didx   = dcnt_q[IW-1:0];

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      acnt_d  = acnt_q;
      dcnt_d  = dcnt_q;
      rw_d    = rw_q;
      err_d   = err_q;
      base_d  = base_q;
      line_d  = line_q;
      tag_d   = tag_q;
`ifdef VX_AHB_WSTRB_EN
      be_d    = be_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (mem_req_valid && ready_q) begin
               state_d = S_BURST;
               rw_d    = mem_req_rw;
               err_d   = 1'b0;
               acnt_d  = '0;
               dcnt_d  = '0;
               base_d  = AHB_ADDR_WIDTH'({mem_req_addr, {LINE_OFS{1'b0}}});
               // read slots start cleared so an aborted read returns zeros past the error
               line_d  = mem_req_rw ? mem_req_data : '0;
               tag_d   = mem_req_tag;
`ifdef VX_AHB_WSTRB_EN
               be_d    = mem_req_byteen;
`endif
            end
         end
         S_BURST: begin
            if (dphase && HRESP && !HREADY) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else if (HREADY) begin
               if (aphase) acnt_d = acnt_q + CW'(1);
               if (dphase) begin
                  if (!rw_q) line_d[didx] = HRDATA;
                  dcnt_d = dcnt_q + CW'(1);
                  if (dcnt_q == CW'(BEATS - 1)) state_d = rw_q ? S_IDLE : S_RESP;
               end
            end
         end
         S_ERR: begin
            if (HREADY) state_d = rw_q ? S_IDLE : S_RESP;
         end
         S_RESP: begin
            if (mem_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         acnt_q  <= '0;
         dcnt_q  <= '0;
         rw_q    <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         base_q  <= '0;
         line_q  <= '0;
         tag_q   <= '0;
`ifdef VX_AHB_WSTRB_EN
         be_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         acnt_q  <= acnt_d;
         dcnt_q  <= dcnt_d;
         rw_q    <= rw_d;
         err_q   <= err_d;
         ready_q <= (state_d == S_IDLE);
         base_q  <= base_d;
         line_q  <= line_d;
         tag_q   <= tag_d;
`ifdef VX_AHB_WSTRB_EN
         be_q    <= be_d;
`endif
      end
   end

   assign mem_req_ready = ready_q;
   assign mem_rsp_valid = (state_q == S_RESP);
   assign mem_rsp_data  = line_q;
   assign mem_rsp_tag   = tag_q;
   assign mem_rsp_err   = err_q;

   // HTRANS drops to IDLE combinationally in the first error cycle to cancel the pending address
   assign HSEL   = aphase;
   assign HTRANS = (aphase && !(dphase && HRESP)) ? ((acnt_q == '0) ? TR_NONSEQ : TR_SEQ) : TR_IDLE;
   assign HADDR  = aphase ? (base_q + (AHB_ADDR_WIDTH'(acnt_q) << BEAT_OFS)) : '0;
   assign HBURST = 3'b001;
   assign HSIZE  = 3'(BEAT_OFS);
   assign HWRITE = aphase && rw_q;
   assign HWDATA = ((state_q == S_BURST) && rw_q) ? line_q[didx] : '0;
`ifdef VX_AHB_WSTRB_EN
   assign HWSTRB = (state_q == S_BURST) ? (rw_q ? be_q[didx] : '1) : '0;
`endif

endmodule

// File: tb/tb_vx_ahb_burst_adapter.sv
// Directed self-checking bench for vx_ahb_burst_adapter with a zero/extended-wait AHB slave model.
module tb_vx_ahb_burst_adapter;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          mem_req_valid = 1'b0, mem_req_rw = 1'b0;
   logic [63:0]   mem_req_byteen = '0;
   logic [25:0]   mem_req_addr = '0;
   logic [511:0]  mem_req_data = '0;
   logic [7:0]    mem_req_tag = '0;
   logic          mem_req_ready, mem_rsp_valid, mem_rsp_err;
   logic          mem_rsp_ready = 1'b1;
   logic [511:0]  mem_rsp_data;
   logic [7:0]    mem_rsp_tag;
   logic          HSEL, HWRITE;
   logic [31:0]   HADDR, HWDATA, HRDATA;
   logic [1:0]    HTRANS;
   logic [2:0]    HBURST, HSIZE;
`ifdef VX_AHB_WSTRB_EN
   logic [3:0]    HWSTRB;
`endif
   logic          hready = 1'b1, hresp = 1'b0;

   int            n_cmp = 0, n_bad = 0;
   logic [31:0]   salt = '0;
   logic [31:0]   dp_addr = '0;
   logic          wdp = 1'b0;
   logic [3:0]    wbeat = '0;
   logic [511:0]  wcap = '0;
   logic [511:0]  expline, wline, held;
   logic          any_rsp;

   always #5 clk = ~clk;

   vx_ahb_burst_adapter dut (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_req_tag(mem_req_tag), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
      .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_err(mem_rsp_err),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
      .HWRITE(HWRITE), .HWDATA(HWDATA),
`ifdef VX_AHB_WSTRB_EN
      .HWSTRB(HWSTRB),
`endif
      .HRDATA(HRDATA), .HREADY(hready), .HRESP(hresp)
   );

   // Slave returns beat index (from the accepted address) xor a per-test salt
   always @(posedge clk) if (HSEL && HTRANS[1] && hready) dp_addr <= HADDR;
   assign HRDATA = 32'(dp_addr[5:2]) ^ salt;

   // Write-beat capture from the data phase following each accepted write address
   always @(posedge clk) begin
      if (wdp && hready) wcap[int'(wbeat)*32 +: 32] <= HWDATA;
      if (hready) begin
         wdp   <= HSEL && HTRANS[1] && HWRITE;
         wbeat <= HADDR[5:2];
      end
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic req(input logic rw, input logic [25:0] addr, input logic [7:0] tag,
                      input logic [511:0] data, input logic [63:0] be);
      mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr;
      mem_req_tag = tag; mem_req_data = data; mem_req_byteen = be;
      #1;
      chk("req_ready", 512'(mem_req_ready), 512'(1'b1));
      tick();
      mem_req_valid = 1'b0;
   endtask

   initial begin
      // reset values
      repeat (3) tick();
      chk("rst_hsel", 512'(HSEL), 512'(1'b0));
      chk("rst_htrans", 512'(HTRANS), 512'(2'b00));
      chk("rst_hwrite", 512'(HWRITE), 512'(1'b0));
      chk("rst_haddr", 512'(HADDR), 512'(32'h0));
      chk("rst_hwdata", 512'(HWDATA), 512'(32'h0));
      chk("rst_ready", 512'(mem_req_ready), 512'(1'b0));
      chk("rst_rspv", 512'(mem_rsp_valid), 512'(1'b0));
      chk("rst_err", 512'(mem_rsp_err), 512'(1'b0));
`ifdef VX_AHB_WSTRB_EN
      chk("rst_hwstrb", 512'(HWSTRB), 512'(4'h0));
`endif
      reset = 1'b1;
      tick();

      // zero-wait read, line 0x10 -> 0x400..0x43C
      salt = 32'h0;
      for (int k = 0; k < 16; k++) expline[k*32 +: 32] = 32'(k);
      req(1'b0, 26'h10, 8'h5A, '0, '1);
      chk("rd_nonseq", 512'(HTRANS), 512'(2'b10));
      chk("rd_addr0", 512'(HADDR), 512'(32'h400));
      chk("rd_hsel", 512'(HSEL), 512'(1'b1));
      chk("rd_hwrite", 512'(HWRITE), 512'(1'b0));
      chk("rd_hburst", 512'(HBURST), 512'(3'b001));
      chk("rd_hsize", 512'(HSIZE), 512'(3'b010));
      for (int k = 1; k < 16; k++) begin
         tick();
         chk("rd_seq", 512'(HTRANS), 512'(2'b11));
         chk("rd_addr", 512'(HADDR), 512'(32'h400 + 32'(k) * 4));
      end
      tick();
      chk("rd_end_idle", 512'(HTRANS), 512'(2'b00));
      chk("rd_end_hsel", 512'(HSEL), 512'(1'b0));
      chk("rd_rspv_t17", 512'(mem_rsp_valid), 512'(1'b0));
      tick();
      chk("rd_rspv_t18", 512'(mem_rsp_valid), 512'(1'b1));
      chk("rd_data", mem_rsp_data, expline);
      chk("rd_tag", 512'(mem_rsp_tag), 512'(8'h5A));
      chk("rd_err", 512'(mem_rsp_err), 512'(1'b0));
      chk("rd_ready_resp", 512'(mem_req_ready), 512'(1'b0));
      tick();
      chk("rd_done_rspv", 512'(mem_rsp_valid), 512'(1'b0));
      chk("rd_done_ready", 512'(mem_req_ready), 512'(1'b1));

      // zero-wait write, byte i = i, line 0x1 -> 0x40
      for (int i = 0; i < 64; i++) wline[i*8 +: 8] = 8'(i);
      any_rsp = 1'b0;
      req(1'b1, 26'h1, 8'h11, wline, '1);
      chk("wr_nonseq", 512'(HTRANS), 512'(2'b10));
      chk("wr_addr0", 512'(HADDR), 512'(32'h40));
      chk("wr_hwrite", 512'(HWRITE), 512'(1'b1));
      tick();
      chk("wr_beat0", 512'(HWDATA), 512'(32'h03020100));
      for (int c = 3; c <= 17; c++) begin
         tick();
         any_rsp = any_rsp | mem_rsp_valid;
      end
      chk("wr_beat15", 512'(HWDATA), 512'(32'h3F3E3D3C));
      chk("wr_ready_t17", 512'(mem_req_ready), 512'(1'b0));
      tick();
      any_rsp = any_rsp | mem_rsp_valid;
      chk("wr_ready_t18", 512'(mem_req_ready), 512'(1'b1));
      chk("wr_line", wcap, wline);
      tick();
      any_rsp = any_rsp | mem_rsp_valid;
      chk("wr_no_rsp", 512'(any_rsp), 512'(1'b0));

      // read with HREADY low for 3 cycles on beat 7, then 5 cycles of response backpressure
      salt = 32'hCAFE0000;
      mem_rsp_ready = 1'b0;
      for (int k = 0; k < 16; k++) expline[k*32 +: 32] = 32'(k) ^ 32'hCAFE0000;
      req(1'b0, 26'h20, 8'hA7, '0, '1);
      for (int c = 2; c <= 8; c++) tick();
      for (int c = 9; c <= 12; c++) begin
         tick();
         hready = (c <= 11) ? 1'b0 : 1'b1;
         #1;
         chk("st_haddr_hold", 512'(HADDR), 512'(32'h820));
         chk("st_htrans_hold", 512'(HTRANS), 512'(2'b11));
         chk("st_hwdata_hold", 512'(HWDATA), 512'(32'h0));
      end
      tick();
      chk("st_haddr_next", 512'(HADDR), 512'(32'h824));
      for (int c = 14; c <= 20; c++) tick();
      chk("st_rspv_t20", 512'(mem_rsp_valid), 512'(1'b0));
      for (int c = 21; c <= 25; c++) begin
         tick();
         chk("bp_rspv", 512'(mem_rsp_valid), 512'(1'b1));
         chk("bp_data", mem_rsp_data, expline);
         chk("bp_tag", 512'(mem_rsp_tag), 512'(8'hA7));
         chk("bp_ready", 512'(mem_req_ready), 512'(1'b0));
      end
      tick();
      mem_rsp_ready = 1'b1;
      chk("bp_still_valid", 512'(mem_rsp_valid), 512'(1'b1));
      tick();
      chk("bp_release_rspv", 512'(mem_rsp_valid), 512'(1'b0));
      chk("bp_release_ready", 512'(mem_req_ready), 512'(1'b1));

      // two-cycle HRESP error on read beat 4
      salt = 32'h0BAD0000;
      expline = '0;
      for (int k = 0; k < 4; k++) expline[k*32 +: 32] = 32'(k) ^ 32'h0BAD0000;
      req(1'b0, 26'h30, 8'hE4, '0, '1);
      for (int c = 2; c <= 6; c++) tick();
      chk("er_pre_seq", 512'(HTRANS), 512'(2'b11));
      hready = 1'b0; hresp = 1'b1;
      #1;
      chk("er_cycle1_idle", 512'(HTRANS), 512'(2'b00));
      tick();
      hready = 1'b1; hresp = 1'b1;
      #1;
      chk("er_cycle2_idle", 512'(HTRANS), 512'(2'b00));
      chk("er_cycle2_rspv", 512'(mem_rsp_valid), 512'(1'b0));
      tick();
      hresp = 1'b0;
      chk("er_rspv", 512'(mem_rsp_valid), 512'(1'b1));
      chk("er_err", 512'(mem_rsp_err), 512'(1'b1));
      chk("er_data", mem_rsp_data, expline);
      chk("er_tag", 512'(mem_rsp_tag), 512'(8'hE4));
      tick();
      chk("er_ready", 512'(mem_req_ready), 512'(1'b1));

      // write interrupted by reset at beat 9; byteen 0x0F covers beat 0 only
      req(1'b1, 26'h3, 8'h33, wline, 64'hF);
      tick();
`ifdef VX_AHB_WSTRB_EN
      chk("ws_beat0", 512'(HWSTRB), 512'(4'hF));
`endif
      tick();
`ifdef VX_AHB_WSTRB_EN
      chk("ws_beat1", 512'(HWSTRB), 512'(4'h0));
`endif
      chk("rs_wdata1", 512'(HWDATA), 512'(32'h07060504));
      for (int c = 4; c <= 10; c++) tick();
      chk("rs_pre_addr", 512'(HADDR), 512'(32'hC0 + 32'd36));
      reset = 1'b0;
      #1;
      chk("rs_htrans", 512'(HTRANS), 512'(2'b00));
      chk("rs_hsel", 512'(HSEL), 512'(1'b0));
      chk("rs_ready", 512'(mem_req_ready), 512'(1'b0));
      tick();
      reset = 1'b1;
      tick();

      // fresh read after reset
      salt = 32'h55550000;
      for (int k = 0; k < 16; k++) expline[k*32 +: 32] = 32'(k) ^ 32'h55550000;
      req(1'b0, 26'h10, 8'hC3, '0, '1);
      chk("fr_addr0", 512'(HADDR), 512'(32'h400));
      for (int c = 2; c <= 18; c++) tick();
      chk("fr_rspv", 512'(mem_rsp_valid), 512'(1'b1));
      chk("fr_data", mem_rsp_data, expline);
      chk("fr_tag", 512'(mem_rsp_tag), 512'(8'hC3));
      chk("fr_err", 512'(mem_rsp_err), 512'(1'b0));
      held = mem_rsp_data;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
